// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-entry holding
// register with valid/ready handshake, framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_txd_i,
  input  logic       ready_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            sync1_q, sync2_q;
  logic            rx;

  assign rx = sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      sync1_q <= uart_txd_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          state_d = rx ? IDLE : DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        // Counter restarts every bit: CLKS_PER_BIT need not be a power of two.
        if (cnt_q == LAST) begin
          shift_d[idx_q] = rx;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit of slack for the next start edge.
        if (cnt_q == LAST) begin
          if (rx) begin
            state_d = IDLE;
            if (!valid_q || ready_i) begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign byte_o      = byte_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frame-level model queues expected bytes and
// error pulses; a negedge monitor checks handshakes and pulses independently.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] byte_o;
  logic       valid_o, ferr_o, ovr_o, busy_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk), .rst_i(rst), .uart_txd_i(txd), .ready_i(ready),
    .byte_o(byte_o), .valid_o(valid_o), .frame_err_o(ferr_o),
    .overrun_o(ovr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int exp_ferr = 0, exp_ovr = 0, ferr_seen = 0, ovr_seen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Frame-level model: decide the outcome from the holding-register occupancy
  // (bytes delivered but not yet accepted) and ready, which is constant per frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_ferr++;
    else if (exp_q.size() > 0 && !ready) exp_ovr++;
    else exp_q.push_back(b);
    txd = 1'b0; tick(CPB);
    for (int k = 0; k < 8; k++) begin txd = b[k]; tick(CPB); end
    txd = stop_ok; tick(CPB);
  endtask

  // Monitor
  logic       prev_valid = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_byte = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0; prev_acc = 1'b0;
    end else begin
      if (ferr_o) ferr_seen++;
      if (ovr_o) ovr_seen++;
      if (prev_acc) chk("valid_fall_after_accept", {31'd0, valid_o}, 32'd0);
      else if (prev_valid && valid_o) chk("byte_stable", {24'd0, byte_o}, {24'd0, prev_byte});
      if (valid_o && ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", byte_o);
        end else begin
          chk("rx_byte", {24'd0, byte_o}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_acc   = valid_o && ready;
      prev_valid = valid_o;
      prev_byte  = byte_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int ferr0;
    tick(3);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_byte", {24'd0, byte_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    rst = 1'b0; tick(5);

    // Held byte, then accept
    send_frame(8'hA5, 1'b1); tick(5);
    chk("a5_valid", {31'd0, valid_o}, 1);
    chk("a5_byte", {24'd0, byte_o}, 32'hA5);
    tick(20);
    chk("a5_held", {31'd0, valid_o}, 1);
    ready = 1'b1; tick(2);
    chk("a5_released", {31'd0, valid_o}, 0);
    ready = 1'b0; tick(5);

    // Start glitch
    bcnt = 0;
    txd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy_o) bcnt++;
      if (i == 3) txd = 1'b1;
    end
    chk("glitch_busy_cycles", bcnt, CPB / 2);
    chk("glitch_no_valid", {31'd0, valid_o}, 0);
    chk("glitch_no_ferr", ferr_seen, exp_ferr);

    // Framing error with held-low line
    ferr0 = ferr_seen;
    send_frame(8'h3C, 1'b0); tick(40);
    chk("ferr_once", ferr_seen - ferr0, 1);
    chk("break_busy", {31'd0, busy_o}, 1);
    chk("ferr_no_valid", {31'd0, valid_o}, 0);
    txd = 1'b1; tick(5);
    chk("break_idle", {31'd0, busy_o}, 0);

    // Overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1); tick(5);
    chk("ovr_byte_kept", {24'd0, byte_o}, 32'h11);
    chk("ovr_pulses", ovr_seen, exp_ovr);
    chk("ovr_expected_one", exp_ovr, 1);
    ready = 1'b1; tick(2);
    chk("ovr_valid_fall", {31'd0, valid_o}, 0);
    ready = 1'b0; tick(5);

    // Reset mid data bit 4 with a byte held
    send_frame(8'h77, 1'b1); tick(5);
    txd = 1'b0; tick(CPB);
    for (int k = 0; k < 4; k++) begin txd = k[0]; tick(CPB); end
    txd = 1'b1; tick(CPB / 2);
    rst = 1'b1; exp_q.delete(); tick(1);
    chk("mid_rst_valid", {31'd0, valid_o}, 0);
    chk("mid_rst_byte", {24'd0, byte_o}, 0);
    chk("mid_rst_busy", {31'd0, busy_o}, 0);
    chk("mid_rst_flags", {30'd0, ferr_o, ovr_o}, 0);
    tick(2); rst = 1'b0; tick(10);
    send_frame(8'h5A, 1'b1); tick(5);
    chk("post_rst_valid", {31'd0, valid_o}, 1);
    chk("post_rst_byte", {24'd0, byte_o}, 32'h5A);
    ready = 1'b1; tick(3);

    // Back-to-back with ready high
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    tick(10);
    chk("b2b_drained", exp_q.size(), 0);

    // Randomized frames, ready and stop errors
    for (int n = 0; n < 16; n++) begin
      bit bad;
      ready = 1'($urandom_range(0, 1));
      txd = 1'b1; tick($urandom_range(1, 20));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(8'($urandom), !bad);
      if (bad) begin tick($urandom_range(0, 30)); txd = 1'b1; end
    end
    txd = 1'b1; tick(10);
    ready = 1'b1; tick(10);

    chk("final_drained", exp_q.size(), 0);
    chk("final_ferr", ferr_seen, exp_ferr);
    chk("final_ovr", ovr_seen, exp_ovr);
    chk("final_idle", {30'd0, busy_o, valid_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
